// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci datapath and its control sequencer.
package fib_pkg;
  localparam int FIB_W = 8;

  typedef enum logic [1:0] {S_INIT, S_MANUAL, S_AUTO} fib_state_t;

  typedef struct packed {
    logic step;
    logic clear;
    logic wrap;
  } fib_cmd_t;

  // A step that would overflow restarts the sequence instead.
  function automatic fib_cmd_t step_req(input logic ovf);
    fib_cmd_t c;
    c.step  = ~ovf;
    c.clear = ovf;
    c.wrap  = ovf;
    return c;
  endfunction
endpackage

// File: rtl/fib_sequencer_if.sv
// Board/datapath side signals of the sequencer: raw buttons, overflow flag, commands.
interface fib_sequencer_if;
  logic [1:0] buttons;
  logic       ovf;
  logic       fib_step;
  logic       fib_clear;
  logic       auto_mode;
  logic       wrapped;

  modport master (input buttons, ovf, output fib_step, fib_clear, auto_mode, wrapped);
  modport slave  (output buttons, ovf, input fib_step, fib_clear, auto_mode, wrapped);
endinterface

// File: rtl/fib_sequencer_debounce.sv
// One button: 2-flop synchroniser, stable-level counter, debounced level and press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic button,   // raw, active low
  output logic level,    // debounced, 1 = held
  output logic press     // combinational, high in the cycle level is about to rise
);
  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             done;

  assign done  = (s2 != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press = done && s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= ~button;
      s2 <= s1;
      if (s2 == level) cnt <= '0;
      else if (done) begin
        level <= s2;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fib_sequencer.sv
// Button/auto-run control sequencer for the 8-bit Fibonacci datapath.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_DIV        = 12000000,
  parameter int CNT_W           = 24
) (
  input  logic            clk,
  input  logic            rst,
  fib_sequencer_if.master bus
);
  if (DEBOUNCE_CYCLES < 1 || AUTO_DIV < 1 ||
      (CNT_W < 31 && ((DEBOUNCE_CYCLES - 1) >= (1 << CNT_W) ||
                      (AUTO_DIV - 1) >= (1 << CNT_W)))) begin : g_bad_cnt_w
    $error("fib_sequencer: CNT_W too small for DEBOUNCE_CYCLES/AUTO_DIV");
  end

  logic [1:0]       level, press;
  logic             both, clr_ev, step_ev;
  fib_state_t       state;
  logic [CNT_W-1:0] acnt;
  fib_cmd_t         cmd;
  logic             auto_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb [1:0] (
    .clk    (clk),
    .rst    (rst),
    .button (bus.buttons),
    .level  (level),
    .press  (press)
  );

  // A press while the other button is already held counts as "both".
  assign both    = (press[0] & press[1]) | (press[0] & level[1]) | (press[1] & level[0]);
  assign clr_ev  = press[1] & ~both;
  assign step_ev = press[0] & ~both;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_INIT;
      acnt   <= '0;
      cmd    <= '0;
      auto_q <= 1'b0;
    end else begin
      cmd <= '0;
      case (state)
        S_INIT: begin
          cmd.clear <= 1'b1;
          state     <= S_MANUAL;
        end
        S_MANUAL: begin
          if (both) begin
            state  <= S_AUTO;
            auto_q <= 1'b1;
            acnt   <= '0;
          end else if (clr_ev)  cmd.clear <= 1'b1;
          else if (step_ev)     cmd       <= step_req(bus.ovf);
        end
        S_AUTO: begin
          if (both) begin
            state  <= S_MANUAL;
            auto_q <= 1'b0;
          end else if (clr_ev) begin
            cmd.clear <= 1'b1;
            acnt      <= '0;
          end else if (acnt == CNT_W'(AUTO_DIV - 1)) begin
            cmd  <= step_req(bus.ovf);
            acnt <= '0;
          end else acnt <= acnt + 1'b1;
        end
        default: begin
          state  <= S_INIT;
          auto_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fib_step  = cmd.step;
  assign bus.fib_clear = cmd.clear;
  assign bus.wrapped   = cmd.wrap;
  assign bus.auto_mode = auto_q;
endmodule
